// File: rtl/id_exe_stage_pkg.sv
// Shared definitions for the ID->EXE pipeline register: widths, operand-select
// encodings, ALU control codes and the register-match helper used by forwarding.
package id_exe_stage_pkg;

    localparam int DATA_W  = 32;
    localparam int RADDR_W = 5;
    localparam int ALUC_W  = 3;

    // Operand-select encodings shared by a/b/store-data muxes in EXE.
    localparam logic [1:0] SEL_REG = 2'b00;
    localparam logic [1:0] SEL_IMM = 2'b01;  // immediate for b, shamt for a
    localparam logic [1:0] SEL_MEM = 2'b10;  // producer is in MEM next cycle
    localparam logic [1:0] SEL_WB  = 2'b11;  // producer is in WB next cycle

    // ALU control codes carried through to EXE.
    localparam logic [ALUC_W-1:0] ALUC_ADD = 3'd0;
    localparam logic [ALUC_W-1:0] ALUC_SUB = 3'd1;
    localparam logic [ALUC_W-1:0] ALUC_AND = 3'd2;
    localparam logic [ALUC_W-1:0] ALUC_OR  = 3'd3;
    localparam logic [ALUC_W-1:0] ALUC_XOR = 3'd4;
    localparam logic [ALUC_W-1:0] ALUC_LUI = 3'd5;
    localparam logic [ALUC_W-1:0] ALUC_SLL = 3'd6;
    localparam logic [ALUC_W-1:0] ALUC_SRL = 3'd7;

    // One-deep record of the instruction now in MEM. The load/ALU choice on
    // the WB path is made downstream from wb_m2reg, so forwarding here only
    // needs the destination and whether it writes.
    typedef struct packed {
        logic [RADDR_W-1:0] rd;
        logic               wreg;
    } mem_shadow_t;

    // A later stage produces register src: it writes, and src is not $0.
    function automatic logic reg_match(input logic [RADDR_W-1:0] src,
                                       input logic [RADDR_W-1:0] rd,
                                       input logic               wreg);
        return wreg && (rd != '0) && (src == rd);
    endfunction

endpackage

// File: rtl/id_exe_stage_fwd_sel.sv
// Forward-code selector: compares one source register number against the
// instruction in EXE and the MEM shadow and returns the 2-bit forward code.
import id_exe_stage_pkg::*;

module id_exe_stage_fwd_sel (
    input  logic [RADDR_W-1:0] src,
    input  logic [RADDR_W-1:0] exe_rd,
    input  logic               exe_wreg,
    input  logic [RADDR_W-1:0] mem_rd,
    input  logic               mem_wreg,
    output logic [1:0]         code
);

    // Youngest producer wins: the EXE instruction shadows an older MEM write.
    always_comb begin
        code = SEL_REG;
        if (reg_match(src, exe_rd, exe_wreg)) begin
            code = SEL_MEM;
        end else if (reg_match(src, mem_rd, mem_wreg)) begin
            code = SEL_WB;
        end
    end

endmodule

// File: rtl/id_exe_stage.sv
// ID->EXE pipeline register for the 5-stage MIPS pipe. Latches operands and
// control, registers the EXE operand selects, detects load-use hazards and
// inserts bubbles. A one-deep MEM shadow feeds the WB-path forward decision.
//
// Flow control: stall is a combinational "hold" to IF/ID. While stall=1 the
// ID instruction must be presented unchanged next cycle; this stage loads a
// bubble in its place. There is no back-pressure into this stage itself.
import id_exe_stage_pkg::*;

module id_exe_stage (
    input  logic                clock,
    input  logic                resetn,
    input  logic                id_valid,
    input  logic                id_flush,
    input  logic [RADDR_W-1:0]  id_rs,
    input  logic [RADDR_W-1:0]  id_rt,
    input  logic                id_use_rs,
    input  logic                id_use_rt,
    input  logic [RADDR_W-1:0]  id_rd,
    input  logic                id_wreg,
    input  logic                id_m2reg,
    input  logic                id_wmem,
    input  logic                id_shift,
    input  logic                id_aluimm,
    input  logic [ALUC_W-1:0]   id_aluc,
    input  logic [DATA_W-1:0]   id_a,
    input  logic [DATA_W-1:0]   id_b,
    input  logic [DATA_W-1:0]   id_imm,
    output logic                stall,
    output logic                exe_valid,
    output logic [DATA_W-1:0]   exe_a,
    output logic [DATA_W-1:0]   exe_b,
    output logic [DATA_W-1:0]   exe_imm,
    output logic [ALUC_W-1:0]   exe_aluc,
    output logic [1:0]          exe_a_select,
    output logic [1:0]          exe_b_select,
    output logic [1:0]          exe_st_select,
    output logic [RADDR_W-1:0]  exe_rd,
    output logic                exe_wreg,
    output logic                exe_m2reg,
    output logic                exe_wmem
);

    mem_shadow_t mem_q;
    logic [1:0]  rs_code;
    logic [1:0]  rt_code;
    logic [1:0]  a_sel_d;
    logic [1:0]  b_sel_d;
    logic [1:0]  st_sel_d;
    logic        rs_hit;
    logic        rt_hit;
    logic        bubble;

    id_exe_stage_fwd_sel u_fwd_rs (
        .src      (id_rs),
        .exe_rd   (exe_rd),
        .exe_wreg (exe_valid & exe_wreg),
        .mem_rd   (mem_q.rd),
        .mem_wreg (mem_q.wreg),
        .code     (rs_code)
    );

    id_exe_stage_fwd_sel u_fwd_rt (
        .src      (id_rt),
        .exe_rd   (exe_rd),
        .exe_wreg (exe_valid & exe_wreg),
        .mem_rd   (mem_q.rd),
        .mem_wreg (mem_q.wreg),
        .code     (rt_code)
    );

    // Load-use detect: the load in EXE has no data until after MEM, so a
    // dependent ID instruction waits one cycle and then picks it up from WB.
    // A shift ignores rs (a comes from shamt), so rs cannot cause a stall.
    always_comb begin
        rs_hit = id_use_rs & ~id_shift & (id_rs == exe_rd);
        rt_hit = id_use_rt & (id_rt == exe_rd);
        stall  = id_valid & ~id_flush & exe_valid & exe_wreg & exe_m2reg
               & (exe_rd != '0) & (rs_hit | rt_hit);
        bubble = stall | id_flush | ~id_valid;
    end

    // Operand selects for EXE, computed here and registered with the operands.
    always_comb begin
        a_sel_d  = SEL_REG;
        b_sel_d  = SEL_REG;
        st_sel_d = SEL_REG;
        if (id_shift) begin
            a_sel_d = SEL_IMM;
        end else if (id_use_rs) begin
            a_sel_d = rs_code;
        end
        if (id_aluimm) begin
            b_sel_d = SEL_IMM;
        end else if (id_use_rt) begin
            b_sel_d = rt_code;
        end
        if (id_wmem & id_use_rt) begin
            st_sel_d = rt_code;
        end
    end

    // ID->EXE register: real instructions are latched, everything else
    // becomes an all-zero bubble.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            exe_valid     <= 1'b0;
            exe_a         <= '0;
            exe_b         <= '0;
            exe_imm       <= '0;
            exe_aluc      <= '0;
            exe_a_select  <= SEL_REG;
            exe_b_select  <= SEL_REG;
            exe_st_select <= SEL_REG;
            exe_rd        <= '0;
            exe_wreg      <= 1'b0;
            exe_m2reg     <= 1'b0;
            exe_wmem      <= 1'b0;
        end else if (bubble) begin
            exe_valid     <= 1'b0;
            exe_a         <= '0;
            exe_b         <= '0;
            exe_imm       <= '0;
            exe_aluc      <= '0;
            exe_a_select  <= SEL_REG;
            exe_b_select  <= SEL_REG;
            exe_st_select <= SEL_REG;
            exe_rd        <= '0;
            exe_wreg      <= 1'b0;
            exe_m2reg     <= 1'b0;
            exe_wmem      <= 1'b0;
        end else begin
            exe_valid     <= 1'b1;
            exe_a         <= id_a;
            exe_b         <= id_b;
            exe_imm       <= id_imm;
            exe_aluc      <= id_aluc;
            exe_a_select  <= a_sel_d;
            exe_b_select  <= b_sel_d;
            exe_st_select <= st_sel_d;
            exe_rd        <= id_rd;
            exe_wreg      <= id_wreg;
            exe_m2reg     <= id_m2reg;
            exe_wmem      <= id_wmem;
        end
    end

    // MEM shadow follows EXE every cycle; MEM never stalls.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            mem_q <= '0;
        end else begin
            mem_q.rd   <= exe_rd;
            mem_q.wreg <= exe_wreg & exe_valid;
        end
    end

endmodule

// File: tb/tb_id_exe_stage.sv
// Bench for id_exe_stage: directed pipeline scenarios plus random traffic,
// checked against an in-flight-producer model of the pipe.
module tb_id_exe_stage;
    import id_exe_stage_pkg::*;

    // ---------------- clock / reset / DUT ----------------
    logic                clock;
    logic                resetn;
    logic                id_valid, id_flush, id_use_rs, id_use_rt;
    logic [RADDR_W-1:0]  id_rs, id_rt, id_rd;
    logic                id_wreg, id_m2reg, id_wmem, id_shift, id_aluimm;
    logic [ALUC_W-1:0]   id_aluc;
    logic [DATA_W-1:0]   id_a, id_b, id_imm;
    logic                stall, exe_valid, exe_wreg, exe_m2reg, exe_wmem;
    logic [DATA_W-1:0]   exe_a, exe_b, exe_imm;
    logic [ALUC_W-1:0]   exe_aluc;
    logic [1:0]          exe_a_select, exe_b_select, exe_st_select;
    logic [RADDR_W-1:0]  exe_rd;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    id_exe_stage dut (
        .clock(clock), .resetn(resetn),
        .id_valid(id_valid), .id_flush(id_flush),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_rd(id_rd), .id_wreg(id_wreg), .id_m2reg(id_m2reg), .id_wmem(id_wmem),
        .id_shift(id_shift), .id_aluimm(id_aluimm), .id_aluc(id_aluc),
        .id_a(id_a), .id_b(id_b), .id_imm(id_imm),
        .stall(stall), .exe_valid(exe_valid),
        .exe_a(exe_a), .exe_b(exe_b), .exe_imm(exe_imm), .exe_aluc(exe_aluc),
        .exe_a_select(exe_a_select), .exe_b_select(exe_b_select),
        .exe_st_select(exe_st_select), .exe_rd(exe_rd),
        .exe_wreg(exe_wreg), .exe_m2reg(exe_m2reg), .exe_wmem(exe_wmem)
    );

    // ---------------- instruction record ----------------
    typedef struct packed {
        logic               valid;
        logic               flush;
        logic [RADDR_W-1:0] rs;
        logic [RADDR_W-1:0] rt;
        logic               use_rs;
        logic               use_rt;
        logic [RADDR_W-1:0] rd;
        logic               wreg;
        logic               m2reg;
        logic               wmem;
        logic               shift;
        logic               aluimm;
        logic [ALUC_W-1:0]  aluc;
        logic [DATA_W-1:0]  a;
        logic [DATA_W-1:0]  b;
        logic [DATA_W-1:0]  imm;
    } instr_t;

    function automatic instr_t mk(input int rd, input int rs, input int rt,
                                  input bit use_rs, input bit use_rt, input bit wreg,
                                  input bit m2reg, input bit wmem, input bit shift,
                                  input bit aluimm);
        instr_t i;
        i.valid  = 1'b1;
        i.flush  = 1'b0;
        i.rd     = RADDR_W'(rd);
        i.rs     = RADDR_W'(rs);
        i.rt     = RADDR_W'(rt);
        i.use_rs = use_rs;
        i.use_rt = use_rt;
        i.wreg   = wreg;
        i.m2reg  = m2reg;
        i.wmem   = wmem;
        i.shift  = shift;
        i.aluimm = aluimm;
        i.aluc   = ALUC_W'($urandom_range(0, 7));
        i.a      = $urandom;
        i.b      = $urandom;
        i.imm    = $urandom;
        return i;
    endfunction

    function automatic instr_t rand_instr();
        instr_t i;
        i = mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
               1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0),
               1'($urandom), ($urandom_range(0, 4) == 0), 1'($urandom));
        i.valid = ($urandom_range(0, 9) != 0);
        i.flush = ($urandom_range(0, 9) == 0);
        return i;
    endfunction

    // ---------------- reference model ----------------
    // Producers still in flight, youngest first: [0] is in EXE, [1] is in MEM.
    typedef struct packed {
        logic               w;
        logic               ld;
        logic [RADDR_W-1:0] rd;
    } prod_t;
    prod_t infl[$];

    function automatic void model_reset();
        infl.delete();
        infl.push_back('0);
        infl.push_back('0);
    endfunction

    // Forward code: how far away the nearest producer of r is.
    function automatic logic [1:0] m_fwd(input logic [RADDR_W-1:0] r);
        if (r == 0) return SEL_REG;
        for (int k = 0; k < infl.size(); k++)
            if (infl[k].w && infl[k].rd == r) return (k == 0) ? SEL_MEM : SEL_WB;
        return SEL_REG;
    endfunction

    // A load one stage ahead that produces a register this instruction reads.
    function automatic logic m_stall(input instr_t i);
        prod_t p;
        p = infl[0];
        if (!i.valid || i.flush) return 1'b0;
        if (!(p.w && p.ld) || p.rd == 0) return 1'b0;
        return (i.use_rs && !i.shift && i.rs == p.rd) || (i.use_rt && i.rt == p.rd);
    endfunction

    function automatic logic [17:0] m_ctrl(input instr_t i, input logic bub);
        logic [1:0] a, b, s;
        if (bub) return '0;
        a = i.shift  ? SEL_IMM : (i.use_rs ? m_fwd(i.rs) : SEL_REG);
        b = i.aluimm ? SEL_IMM : (i.use_rt ? m_fwd(i.rt) : SEL_REG);
        s = (i.wmem && i.use_rt) ? m_fwd(i.rt) : SEL_REG;
        return {1'b1, a, b, s, i.rd, i.wreg, i.m2reg, i.wmem, i.aluc};
    endfunction

    function automatic logic [17:0] dut_ctrl();
        return {exe_valid, exe_a_select, exe_b_select, exe_st_select, exe_rd,
                exe_wreg, exe_m2reg, exe_wmem, exe_aluc};
    endfunction

    // ---------------- scoreboard ----------------
    logic [17:0] exp_q[$];
    logic [95:0] exp_d_q[$];
    int          n_total = 0;
    int          n_bad   = 0;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic drive(input instr_t i);
        id_valid = i.valid;  id_flush = i.flush;
        id_rs = i.rs;        id_rt = i.rt;
        id_use_rs = i.use_rs; id_use_rt = i.use_rt;
        id_rd = i.rd;        id_wreg = i.wreg;  id_m2reg = i.m2reg;
        id_wmem = i.wmem;    id_shift = i.shift; id_aluimm = i.aluimm;
        id_aluc = i.aluc;    id_a = i.a;  id_b = i.b;  id_imm = i.imm;
    endtask

    // Present one instruction for one clock; st reports the model's stall.
    task automatic issue(input instr_t i, output logic st);
        logic  bub;
        prod_t e;
        drive(i);
        @(negedge clock);
        st = m_stall(i);
        chk("stall", stall, st);
        bub = st | i.flush | ~i.valid;
        exp_q.push_back(m_ctrl(i, bub));
        exp_d_q.push_back(bub ? 96'd0 : {i.a, i.b, i.imm});
        @(posedge clock);
        #1;
        e = '0;
        if (!bub) begin
            e.w  = i.wreg;
            e.ld = i.m2reg;
            e.rd = i.rd;
        end
        infl.push_front(e);
        void'(infl.pop_back());
        chk("exe_ctrl", dut_ctrl(), exp_q.pop_front());
        chk("exe_data", {exe_a, exe_b, exe_imm}, exp_d_q.pop_front());
    endtask

    // Hold the instruction in ID until it is accepted (IF/ID frozen by stall).
    task automatic run(input instr_t i, output int n_st);
        logic st;
        n_st = 0;
        st   = 1'b1;
        while (st && n_st < 4) begin
            issue(i, st);
            if (st) n_st++;
        end
        chk("stall_bound", st, 1'b0);
    endtask

    task automatic idle(input int n);
        instr_t nop;
        logic   st;
        nop = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        nop.valid = 1'b0;
        for (int k = 0; k < n; k++) issue(nop, st);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        instr_t i;
        int     ns;
        logic   st;

        // Reset with random inputs: everything must read zero.
        model_reset();
        resetn = 1'b0;
        drive(rand_instr());
        id_valid = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_ctrl", dut_ctrl(), 18'd0);
        chk("rst_data", {exe_a, exe_b, exe_imm}, 96'd0);
        chk("rst_stall", stall, 1'b0);
        i = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        i.valid = 1'b0;
        drive(i);
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock);
        #1;

        // add $3,$1,$2 ; sub $4,$3,$5 -> EXE forward on a
        run(mk(3, 1, 2, 1, 1, 1, 0, 0, 0, 0), ns);
        chk("first_valid", exe_valid, 1'b1);
        run(mk(4, 3, 5, 1, 1, 1, 0, 0, 0, 0), ns);
        chk("sub_a_mem", exe_a_select, SEL_MEM);
        chk("sub_b_reg", exe_b_select, SEL_REG);

        // add $3 ; independent ; sub $4,$3,$5 -> WB forward on a
        idle(2);
        run(mk(3, 1, 2, 1, 1, 1, 0, 0, 0, 0), ns);
        run(mk(6, 7, 8, 1, 1, 1, 0, 0, 0, 0), ns);
        run(mk(4, 3, 5, 1, 1, 1, 0, 0, 0, 0), ns);
        chk("gap_a_wb", exe_a_select, SEL_WB);

        // lw $3,0($1) ; add $4,$3,$3 -> one stall, then WB forward on both
        idle(2);
        run(mk(3, 1, 0, 1, 0, 1, 1, 0, 0, 1), ns);
        run(mk(4, 3, 3, 1, 1, 1, 0, 0, 0, 0), ns);
        chk("lu_stall_cycles", ns, 1);
        chk("lu_a_wb", exe_a_select, SEL_WB);
        chk("lu_b_wb", exe_b_select, SEL_WB);

        // $0 is never forwarded and never stalls
        idle(2);
        run(mk(0, 1, 2, 1, 1, 1, 0, 0, 0, 0), ns);
        run(mk(5, 0, 0, 1, 1, 1, 0, 0, 0, 0), ns);
        chk("r0_a", exe_a_select, SEL_REG);
        chk("r0_b", exe_b_select, SEL_REG);
        run(mk(0, 1, 0, 1, 0, 1, 1, 0, 0, 1), ns);
        run(mk(6, 0, 0, 1, 1, 1, 0, 0, 0, 0), ns);
        chk("lw0_no_stall", ns, 0);

        // add $2 ; sll $2,$3,4 ; sw $2,8($2) -> EXE match beats MEM match
        idle(2);
        run(mk(2, 1, 1, 1, 1, 1, 0, 0, 0, 0), ns);
        i = mk(2, 0, 3, 0, 1, 1, 0, 0, 1, 0);
        i.imm = 32'd4 << 5;
        run(i, ns);
        chk("sll_a_imm", exe_a_select, SEL_IMM);
        run(mk(0, 2, 2, 1, 1, 0, 0, 1, 0, 1), ns);
        chk("sw_a_mem", exe_a_select, SEL_MEM);
        chk("sw_b_imm", exe_b_select, SEL_IMM);
        chk("sw_st_mem", exe_st_select, SEL_MEM);

        // flush during a load-use condition: no stall, bubble
        idle(2);
        run(mk(3, 1, 0, 1, 0, 1, 1, 0, 0, 1), ns);
        i = mk(4, 3, 3, 1, 1, 1, 0, 0, 0, 0);
        i.flush = 1'b1;
        issue(i, st);
        chk("flush_bubble", exe_valid, 1'b0);

        // reset asserted mid-stall: stall drops without a clock
        idle(2);
        run(mk(3, 1, 0, 1, 0, 1, 1, 0, 0, 1), ns);
        drive(mk(4, 3, 3, 1, 1, 1, 0, 0, 0, 0));
        #1;
        chk("pre_reset_stall", stall, 1'b1);
        resetn = 1'b0;
        #1;
        chk("async_stall_drop", stall, 1'b0);
        chk("async_exe_clear", dut_ctrl(), 18'd0);
        model_reset();
        i = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        i.valid = 1'b0;
        drive(i);
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock);
        #1;

        // random traffic
        for (int n = 0; n < 300; n++) begin
            run(rand_instr(), ns);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    // Guard against a hung run.
    initial begin
        #200000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
